hop_scan_seq: RTL and testbench

- Next-generation scan-chain programmer for the hop controller. It serialises a configuration word into the chip scan chain using the four-phase scheme phi, idle, phi_bar, idle, followed by a load strobe.
- Adds the following over the fixed-function version:
  - start/busy/done handshake
  - runtime bit count and shift order
  - parametrised phase stretching
  - readback capture of the chain output
  - abort
- Sits between the control register block (supplies word, count and start) and the chip scan pins.

---
 rtl/hop_pkg.sv | 27 ++
 rtl/scan_phase_gen.sv | 52 +++++
 rtl/hop_scan_seq.sv | 152 +++++++++++++++
 tb/tb_hop_scan_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hop_pkg.sv
// Shared types and constants for the hop controller scan-chain programmer.
package hop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] PH_PHI  = 2'd0;
    localparam logic [1:0] PH_GAP0 = 2'd1;
    localparam logic [1:0] PH_PHIB = 2'd2;
    localparam logic [1:0] PH_GAP1 = 2'd3;

    localparam logic [31:0] DEFAULT_WORD = 32'h15428193;

    function automatic logic [1:0] next_phase(input logic [1:0] phase);
        case (phase)
            PH_PHI:  return PH_GAP0;
            PH_GAP0: return PH_PHIB;
            PH_PHIB: return PH_GAP1;
            default: return PH_PHI;
        endcase
    endfunction

endpackage

// File: rtl/scan_phase_gen.sv
// Four-phase scan timing: a divider of PHASE_CYCLES clocks per phase and a
// phase index that wraps after the second gap, with end-of-phase/bit strobes.
module scan_phase_gen
    import hop_pkg::*;
#(
    parameter int PHASE_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       clr_i,
    output logic [1:0] phase_o,
    output logic       phase_last_o,
    output logic       bit_last_o
);

    localparam int DIVW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

    logic [DIVW-1:0] div_q, div_d;
    logic [1:0]      phase_q, phase_d;

    assign phase_o      = phase_q;
    assign phase_last_o = (div_q == DIVW'(PHASE_CYCLES - 1));
    assign bit_last_o   = phase_last_o && (phase_q == PH_GAP1);

    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        if (clr_i) begin
            div_d   = '0;
            phase_d = PH_PHI;
        end else if (en_i) begin
            if (phase_last_o) begin
                div_d   = '0;
                phase_d = next_phase(phase_q);
            end else begin
                div_d = div_q + DIVW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= '0;
            phase_q <= PH_PHI;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/hop_scan_seq.sv
// Scan-chain programmer: serialises a latched word with the phi/idle/phi_bar/idle
// scheme, captures the chain output, then strobes the parallel load.
module hop_scan_seq
    import hop_pkg::*;
#(
    parameter int TX_BITS_WIDTH = 128,
    parameter int BIT_CNT_WIDTH = 8,
    parameter int PHASE_CYCLES  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [BIT_CNT_WIDTH-1:0] nbits,
    input  logic                     msb_first,
    input  logic [TX_BITS_WIDTH-1:0] data_in,
    input  logic                     scan_data_out,
    output logic                     busy,
    output logic                     done,
    output logic [TX_BITS_WIDTH-1:0] rd_data,
    output logic                     scan_id,
    output logic                     scan_phi,
    output logic                     scan_phi_bar,
    output logic                     scan_data_in,
    output logic                     scan_load_chip,
    output logic [BIT_CNT_WIDTH-1:0] nbits_cnt,
    output logic [1:0]               state_dbg
);

    state_e                   state_q, state_d;
    logic [BIT_CNT_WIDTH-1:0] n_q, n_d, bit_q, bit_d, n_in, idx_q, idx_d;
    logic                     msb_q, msb_d;
    logic [TX_BITS_WIDTH-1:0] word_q, word_d, rd_q, rd_d, word_sh;
    logic                     busy_q, done_q, id_q, phi_q, phib_q, din_q, load_q;
    logic                     din_d, en, clr, phase_last, bit_last;
    logic [1:0]               phase, phase_nxt;

    scan_phase_gen #(.PHASE_CYCLES(PHASE_CYCLES)) u_phase (
        .clk_i       (clk),
        .rst_ni      (reset),
        .en_i        (en),
        .clr_i       (clr),
        .phase_o     (phase),
        .phase_last_o(phase_last),
        .bit_last_o  (bit_last)
    );

    assign en        = ((state_q == SHIFT) || (state_q == LOAD)) && !abort;
    assign clr       = !en;
    assign phase_nxt = clr ? PH_PHI : (phase_last ? next_phase(phase) : phase);

    assign n_in  = (nbits > BIT_CNT_WIDTH'(TX_BITS_WIDTH)) ? BIT_CNT_WIDTH'(TX_BITS_WIDTH) : nbits;
    assign idx_q = msb_q ? (n_q - BIT_CNT_WIDTH'(1) - bit_q) : bit_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        msb_d   = msb_q;
        word_d  = word_q;
        rd_d    = rd_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d    = n_in;
                    msb_d  = msb_first;
                    word_d = (data_in[3:0] == 4'd0) ? TX_BITS_WIDTH'(DEFAULT_WORD) : data_in;
                    rd_d   = '0;
                    bit_d  = '0;
                    state_d = (n_in == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    rd_d    = '0;
                    bit_d   = '0;
                end else if (bit_last) begin
                    rd_d = rd_q | (TX_BITS_WIDTH'(scan_data_out) << idx_q);
                    if (bit_q == n_q - BIT_CNT_WIDTH'(1)) begin
                        state_d = LOAD;
                    end else begin
                        bit_d = bit_q + BIT_CNT_WIDTH'(1);
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    rd_d    = '0;
                    bit_d   = '0;
                end else if (bit_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                bit_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so the scan pins are clean flop outputs.
    assign idx_d   = msb_d ? (n_d - BIT_CNT_WIDTH'(1) - bit_d) : bit_d;
    assign word_sh = word_d >> idx_d;
    assign din_d   = (state_d == SHIFT) && word_sh[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            msb_q   <= 1'b0;
            word_q  <= '0;
            rd_q    <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            id_q    <= 1'b0;
            phi_q   <= 1'b0;
            phib_q  <= 1'b0;
            din_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            msb_q   <= msb_d;
            word_q  <= word_d;
            rd_q    <= rd_d;
            bit_q   <= bit_d;
            busy_q  <= (state_d == SHIFT) || (state_d == LOAD);
            done_q  <= (state_d == DONE);
            id_q    <= (state_d == SHIFT) || (state_d == LOAD);
            phi_q   <= (state_d == SHIFT) && (phase_nxt == PH_PHI);
            phib_q  <= (state_d == SHIFT) && (phase_nxt == PH_PHIB);
            din_q   <= din_d;
            load_q  <= (state_d == LOAD) && (phase_nxt == PH_GAP1);
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign rd_data        = rd_q;
    assign scan_id        = id_q;
    assign scan_phi       = phi_q;
    assign scan_phi_bar   = phib_q;
    assign scan_data_in   = din_q;
    assign scan_load_chip = load_q;
    assign nbits_cnt      = bit_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_hop_scan_seq.sv
// Directed bench for hop_scan_seq: one instance with single-cycle phases and
// one with three-cycle phases, chain output looped back to chain input.
module tb_hop_scan_seq;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start1 = 1'b0;
    logic         start3 = 1'b0;
    logic         abort = 1'b0;
    logic         msbFirst = 1'b0;
    logic [7:0]   nbits = 8'd0;
    logic [127:0] dataIn = '0;
    bit           useP3 = 1'b0;

    logic         busy1, done1, id1, phi1, phib1, din1, load1;
    logic [127:0] rd1;
    logic [7:0]   cnt1;
    logic [1:0]   st1;
    logic         busy3, done3, id3, phi3, phib3, din3, load3;
    logic [127:0] rd3;
    logic [7:0]   cnt3;
    logic [1:0]   st3;

    logic         oBusy, oDone, oId, oPhi, oPhib, oDin, oLoad;
    logic [127:0] oRd;
    logic [7:0]   oCnt;
    logic [1:0]   oSt;

    int total = 0;
    int bad = 0;
    int doneCyc;
    logic [127:0] rdAtDone;

    logic phiTr[0:600], phibTr[0:600], dinTr[0:600], loadTr[0:600];
    logic busyTr[0:600], idTr[0:600], doneTr[0:600], rdNzTr[0:600];
    logic [7:0] cntTr[0:600];
    logic [1:0] stTr[0:600];

    always #5 clk = ~clk;

    hop_scan_seq #(.TX_BITS_WIDTH(128), .BIT_CNT_WIDTH(8), .PHASE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort), .nbits(nbits),
        .msb_first(msbFirst), .data_in(dataIn), .scan_data_out(din1),
        .busy(busy1), .done(done1), .rd_data(rd1), .scan_id(id1), .scan_phi(phi1),
        .scan_phi_bar(phib1), .scan_data_in(din1), .scan_load_chip(load1),
        .nbits_cnt(cnt1), .state_dbg(st1)
    );

    hop_scan_seq #(.TX_BITS_WIDTH(128), .BIT_CNT_WIDTH(8), .PHASE_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .abort(abort), .nbits(nbits),
        .msb_first(msbFirst), .data_in(dataIn), .scan_data_out(din3),
        .busy(busy3), .done(done3), .rd_data(rd3), .scan_id(id3), .scan_phi(phi3),
        .scan_phi_bar(phib3), .scan_data_in(din3), .scan_load_chip(load3),
        .nbits_cnt(cnt3), .state_dbg(st3)
    );

    assign oBusy = useP3 ? busy3 : busy1;
    assign oDone = useP3 ? done3 : done1;
    assign oId   = useP3 ? id3   : id1;
    assign oPhi  = useP3 ? phi3  : phi1;
    assign oPhib = useP3 ? phib3 : phib1;
    assign oDin  = useP3 ? din3  : din1;
    assign oLoad = useP3 ? load3 : load1;
    assign oRd   = useP3 ? rd3   : rd1;
    assign oCnt  = useP3 ? cnt3  : cnt1;
    assign oSt   = useP3 ? st3   : st1;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Start one operation at edge 0 and record outputs mid-cycle for cycles 1..limit.
    task automatic applyStimulus(input bit p3, input int n, input logic msb, input logic [127:0] data,
                                 input int limit, input int restartCyc, input int abortCyc);
        @(negedge clk);
        useP3    = p3;
        nbits    = n[7:0];
        msbFirst = msb;
        dataIn   = data;
        if (p3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1   = 1'b0;
        start3   = 1'b0;
        doneCyc  = -1;
        rdAtDone = '0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            phiTr[c]  = oPhi;
            phibTr[c] = oPhib;
            dinTr[c]  = oDin;
            loadTr[c] = oLoad;
            busyTr[c] = oBusy;
            idTr[c]   = oId;
            doneTr[c] = oDone;
            rdNzTr[c] = |oRd;
            cntTr[c]  = oCnt;
            stTr[c]   = oSt;
            if (oDone && doneCyc < 0) begin
                doneCyc  = c;
                rdAtDone = oRd;
            end
            if (c == restartCyc) begin
                nbits  = 8'd8;
                dataIn = 128'h6;
                if (p3) start3 = 1'b1; else start1 = 1'b1;
            end else if (c == restartCyc + 1) begin
                start1 = 1'b0;
                start3 = 1'b0;
            end
            if (c == abortCyc) abort = 1'b1;
            else if (c == abortCyc + 1) abort = 1'b0;
        end
    endtask

    function automatic logic [127:0] traceBits(input int which, input int first, input int count, input int stride);
        logic [127:0] v;
        int c;
        v = '0;
        for (int i = 0; i < count; i++) begin
            c = first + i * stride;
            case (which)
                0: v[i] = phiTr[c];
                1: v[i] = phibTr[c];
                2: v[i] = dinTr[c];
                3: v[i] = loadTr[c];
                4: v[i] = busyTr[c];
                default: v[i] = idTr[c];
            endcase
        end
        return v;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] hop_scan_seq directed test");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outs1", {busy1, done1, id1, phi1, phib1, din1, load1, st1, cnt1}, '0);
        checkOutput("reset_rd1", rd1, '0);
        checkOutput("reset_outs3", {busy3, done3, id3, phi3, phib3, din3, load3, st3, cnt3}, '0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // P=1, N=4, LSB first, ...1011
        applyStimulus(1'b0, 4, 1'b0, 128'hB, 24, -10, -10);
        checkOutput("lsb_phi",  traceBits(0, 1, 20, 1), 128'h01111);
        checkOutput("lsb_phib", traceBits(1, 1, 20, 1), 128'h04444);
        checkOutput("lsb_load", traceBits(3, 1, 20, 1), 128'h80000);
        checkOutput("lsb_busy", traceBits(4, 1, 20, 1), 128'hFFFFF);
        checkOutput("lsb_id",   traceBits(5, 1, 20, 1), 128'hFFFFF);
        checkOutput("lsb_din",  traceBits(2, 1, 16, 1), 128'hF0FF);
        checkOutput("lsb_done", doneCyc, 21);
        checkOutput("lsb_rd",   rdAtDone, 128'hB);
        checkOutput("lsb_idle_at_done", {busyTr[21], idTr[21], loadTr[21], phiTr[21], doneTr[22]}, '0);

        // Same word, MSB first
        applyStimulus(1'b0, 4, 1'b1, 128'hB, 24, -10, -10);
        checkOutput("msb_din",  traceBits(2, 1, 16, 1), 128'hFF0F);
        checkOutput("msb_done", doneCyc, 21);
        checkOutput("msb_rd",   rdAtDone, 128'hB);

        // P=3, N=1, 0101
        applyStimulus(1'b1, 1, 1'b0, 128'h5, 28, -10, -10);
        checkOutput("p3_phi",  traceBits(0, 1, 24, 1), 128'h000007);
        checkOutput("p3_phib", traceBits(1, 1, 24, 1), 128'h0001C0);
        checkOutput("p3_load", traceBits(3, 1, 24, 1), 128'hE00000);
        checkOutput("p3_din",  traceBits(2, 1, 12, 1), 128'hFFF);
        checkOutput("p3_busy", traceBits(4, 1, 25, 1), 128'h0FFFFFF);
        checkOutput("p3_done", doneCyc, 25);

        // data_in low nibble zero selects the default word
        applyStimulus(1'b0, 32, 1'b0, 128'h0, 136, -10, -10);
        checkOutput("dflt_stream", traceBits(2, 1, 32, 4), 128'h15428193);
        checkOutput("dflt_rd",     rdAtDone, 128'h15428193);
        checkOutput("dflt_done",   doneCyc, 133);

        // N=0 finishes immediately with no scan activity
        applyStimulus(1'b0, 0, 1'b0, 128'hB, 6, -10, -10);
        checkOutput("n0_done", doneCyc, 1);
        checkOutput("n0_id",   traceBits(5, 1, 6, 1), '0);
        checkOutput("n0_busy", traceBits(4, 1, 6, 1), '0);

        // N=200 clamps to 128 bits
        applyStimulus(1'b0, 200, 1'b0, 128'h0123456789ABCDEF0F1E2D3C4B5A6978, 520, -10, -10);
        checkOutput("clamp_done", doneCyc, 517);
        checkOutput("clamp_rd",   rdAtDone, 128'h0123456789ABCDEF0F1E2D3C4B5A6978);
        checkOutput("clamp_cnt",  cntTr[509], 127);

        // Second start while busy is ignored
        applyStimulus(1'b0, 4, 1'b0, 128'hB, 24, 6, -10);
        checkOutput("restart_din",  traceBits(2, 1, 16, 1), 128'hF0FF);
        checkOutput("restart_done", doneCyc, 21);
        checkOutput("restart_rd",   rdAtDone, 128'hB);

        // Abort during bit 3, then a fresh start
        applyStimulus(1'b0, 4, 1'b0, 128'hB, 30, -10, 14);
        checkOutput("abort_bit", cntTr[14], 3);
        checkOutput("abort_outs", {busyTr[15], idTr[15], phiTr[15], phibTr[15], dinTr[15],
                                   loadTr[15], doneTr[15], rdNzTr[15], stTr[15], cntTr[15]}, '0);
        checkOutput("abort_nodone", doneCyc, -1);
        applyStimulus(1'b0, 4, 1'b1, 128'hB, 24, -10, -10);
        checkOutput("post_abort_din",  traceBits(2, 1, 16, 1), 128'hFF0F);
        checkOutput("post_abort_done", doneCyc, 21);

        // Reset asserted in LOAD clears outputs without a clock edge
        @(negedge clk);
        useP3 = 1'b0;
        nbits = 8'd4;
        msbFirst = 1'b0;
        dataIn = 128'hB;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (18) @(negedge clk);
        checkOutput("pre_reset_load", {busy1, id1, st1}, {1'b1, 1'b1, 2'd2});
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_outs", {busy1, done1, id1, phi1, phib1, din1, load1, st1, cnt1}, '0);
        checkOutput("async_reset_rd", rd1, '0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 4, 1'b0, 128'hB, 24, -10, -10);
        checkOutput("post_reset_done", doneCyc, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
